// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for the DE->EX issue point of the 5-stage pipeline.
// Each architectural register has an entry recording whether a write to it
// is in flight, whether that write comes from a variable-latency ("long")
// unit, whether it is a load, and how many cycles ago it issued. The
// instruction in DE is checked against these entries combinationally to
// produce per-operand forwarding selects and a single stall.
//
// Handshake: issue_valid means DE holds an instruction that wants to enter
// EX. The instruction moves into EX in a cycle where issue_accept is high
// (issue_valid & !stall & !flush). When stall is high DE and fetch hold and
// a bubble goes into EX. issue_valid may drop at any time; flush squashes
// the DE instruction regardless of stall.
module hazard_scoreboard #(
  parameter int NUM_SRC    = 2,
  parameter int REG_W      = 5,
  parameter int BYPASS_MEM = 1,
  parameter int BYPASS_WB  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue_valid,
  input  logic                     issue_we,
  input  logic [REG_W-1:0]         issue_rd,
  input  logic [1:0]               issue_lat,
  input  logic [NUM_SRC*REG_W-1:0] src_addr,
  input  logic [NUM_SRC-1:0]       src_used,
  input  logic                     flush,
  input  logic                     cmpl_valid,
  input  logic [REG_W-1:0]         cmpl_rd,
  output logic                     stall,
  output logic                     issue_accept,
  output logic [NUM_SRC*2-1:0]     fwd_sel,
  output logic [31:0]              stall_count
);

  localparam int NREG = 1 << REG_W;

  localparam logic [1:0] SEL_REG = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_WB  = 2'd2;

  // Per-register scoreboard state. Entry 0 is never written.
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] long_q;
  logic [NREG-1:0] load_q;
  logic [1:0]      age_q [NREG];

  logic [REG_W-1:0]   src_a     [NUM_SRC];
  logic [1:0]         op_sel    [NUM_SRC];
  logic [NUM_SRC-1:0] op_hazard;
  logic               waw;
  logic               issue_long;
  logic               issue_load;
  logic               issue_record;

  // Per-operand hazard and forwarding-select evaluation.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_a[i]     = src_addr[i*REG_W +: REG_W];
      op_sel[i]    = SEL_REG;
      op_hazard[i] = 1'b0;
      if (src_used[i] && (src_a[i] != '0) && busy_q[src_a[i]]) begin
        if (long_q[src_a[i]]) begin
          // The write-through regfile makes a completing long result
          // readable from REG in the completion cycle.
          if (!(cmpl_valid && (cmpl_rd == src_a[i]))) op_hazard[i] = 1'b1;
        end else if (age_q[src_a[i]] == 2'd1) begin
          if (load_q[src_a[i]]) begin
            op_hazard[i] = 1'b1;
          end else begin
            op_sel[i] = SEL_MEM;
            if (BYPASS_MEM == 0) op_hazard[i] = 1'b1;
          end
        end else begin
          op_sel[i] = SEL_WB;
          if (BYPASS_WB == 0) op_hazard[i] = 1'b1;
        end
      end
    end
  end

  // Write-after-write against a pending long producer, plus stall/accept.
  always_comb begin
    waw = issue_we && (issue_rd != '0) && busy_q[issue_rd] && long_q[issue_rd] &&
          !(cmpl_valid && (cmpl_rd == issue_rd));
    stall        = !reset && issue_valid && ((|op_hazard) || waw);
    issue_accept = issue_valid && !stall && !flush;
    issue_record = issue_accept && issue_we && (issue_rd != '0);
    issue_long   = (issue_lat == 2'd3);
    issue_load   = (issue_lat == 2'd2);
  end

  // Pack forwarding selects; forced to REG while reset is held.
  always_comb begin
    fwd_sel = '0;
    if (!reset) begin
      for (int i = 0; i < NUM_SRC; i++) fwd_sel[i*2 +: 2] = op_sel[i];
    end
  end

  // Scoreboard update: aging, then completion, then issue (newest wins).
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q      <= '0;
      long_q      <= '0;
      load_q      <= '0;
      stall_count <= '0;
      for (int r = 0; r < NREG; r++) age_q[r] <= 2'd0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (busy_q[r] && !long_q[r]) begin
          age_q[r] <= age_q[r] + 2'd1;
          if (age_q[r] == 2'd2) busy_q[r] <= 1'b0;
        end
        if (cmpl_valid && (cmpl_rd == REG_W'(r)) && busy_q[r] && long_q[r]) begin
          busy_q[r] <= 1'b0;
        end
      end
      if (issue_record) begin
        busy_q[issue_rd] <= 1'b1;
        long_q[issue_rd] <= issue_long;
        load_q[issue_rd] <= issue_load;
        age_q[issue_rd]  <= 2'd1;
      end
      if (issue_valid && stall) stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. Three instances share one set of
// inputs: full bypass, no MEM bypass, and no bypass at all. A vector table
// drives the full-bypass instance cycle by cycle; a short hand sequence
// then covers the disabled-bypass stalls.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_we;
  logic [4:0]  issue_rd;
  logic [1:0]  issue_lat;
  logic [9:0]  src_addr;
  logic [1:0]  src_used;
  logic        flush;
  logic        cmpl_valid;
  logic [4:0]  cmpl_rd;

  logic        stall0, stall1, stall2;
  logic        acc0, acc1, acc2;
  logic [3:0]  fwd0, fwd1, fwd2;
  logic [31:0] cnt0, cnt1, cnt2;

  int n_cmp = 0;
  int n_err = 0;

  // clock
  always #5 clk = ~clk;

  hazard_scoreboard u0 (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_rd(issue_rd), .issue_lat(issue_lat), .src_addr(src_addr), .src_used(src_used),
    .flush(flush), .cmpl_valid(cmpl_valid), .cmpl_rd(cmpl_rd),
    .stall(stall0), .issue_accept(acc0), .fwd_sel(fwd0), .stall_count(cnt0)
  );

  hazard_scoreboard #(.BYPASS_MEM(0)) u1 (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_rd(issue_rd), .issue_lat(issue_lat), .src_addr(src_addr), .src_used(src_used),
    .flush(flush), .cmpl_valid(cmpl_valid), .cmpl_rd(cmpl_rd),
    .stall(stall1), .issue_accept(acc1), .fwd_sel(fwd1), .stall_count(cnt1)
  );

  hazard_scoreboard #(.BYPASS_MEM(0), .BYPASS_WB(0)) u2 (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_rd(issue_rd), .issue_lat(issue_lat), .src_addr(src_addr), .src_used(src_used),
    .flush(flush), .cmpl_valid(cmpl_valid), .cmpl_rd(cmpl_rd),
    .stall(stall2), .issue_accept(acc2), .fwd_sel(fwd2), .stall_count(cnt2)
  );

  typedef struct {
    logic        rst, iv, we;
    logic [4:0]  rd;
    logic [1:0]  lat;
    logic [4:0]  s0, s1;
    logic [1:0]  used;
    logic        fl, cv;
    logic [4:0]  crd;
    logic        e_stall, e_acc;
    logic [3:0]  e_fwd;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic iv, input logic we,
                              input logic [4:0] rd, input logic [1:0] lat,
                              input logic [4:0] s0, input logic [4:0] s1,
                              input logic [1:0] used, input logic fl, input logic cv,
                              input logic [4:0] crd, input logic e_stall,
                              input logic e_acc, input logic [3:0] e_fwd,
                              input logic [31:0] e_cnt);
    vec_t v;
    v.rst = rst; v.iv = iv; v.we = we; v.rd = rd; v.lat = lat;
    v.s0 = s0; v.s1 = s1; v.used = used; v.fl = fl; v.cv = cv; v.crd = crd;
    v.e_stall = e_stall; v.e_acc = e_acc; v.e_fwd = e_fwd; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic iv, input logic we,
                       input logic [4:0] rd, input logic [1:0] lat,
                       input logic [4:0] s0, input logic [4:0] s1,
                       input logic [1:0] used, input logic fl, input logic cv,
                       input logic [4:0] crd);
    reset       = rst;
    issue_valid = iv;
    issue_we    = we;
    issue_rd    = rd;
    issue_lat   = lat;
    src_addr    = {s1, s0};
    src_used    = used;
    flush       = fl;
    cmpl_valid  = cv;
    cmpl_rd     = crd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Table: rst iv we rd lat | s0 s1 used | fl cv crd | stall acc fwd count
    tbl.push_back(mk(1, 1, 1, 5,  1,  5, 0, 2'b01, 0, 0, 0,  0, 1, 4'h0,   0)); // R0 outputs in reset
    tbl.push_back(mk(0, 1, 1, 5,  1,  1, 2, 2'b11, 0, 0, 0,  0, 1, 4'h0,   0)); // R1 add x5
    tbl.push_back(mk(0, 1, 0, 0,  1,  5, 0, 2'b01, 0, 0, 0,  0, 1, 4'b0001, 0)); // R2 x5 from MEM
    tbl.push_back(mk(0, 1, 0, 0,  1,  3, 5, 2'b11, 0, 0, 0,  0, 1, 4'b1000, 0)); // R3 x5 from WB
    tbl.push_back(mk(0, 1, 0, 0,  1,  5, 0, 2'b01, 0, 0, 0,  0, 1, 4'h0,   0)); // R4 x5 from REG
    tbl.push_back(mk(0, 1, 1, 7,  2,  0, 0, 2'b00, 0, 0, 0,  0, 1, 4'h0,   0)); // R5 load x7
    tbl.push_back(mk(0, 1, 0, 0,  1,  7, 0, 2'b01, 0, 0, 0,  1, 0, 4'h0,   0)); // R6 load-use
    tbl.push_back(mk(0, 1, 0, 0,  1,  7, 0, 2'b01, 0, 0, 0,  0, 1, 4'b0010, 1)); // R7 x7 from WB
    tbl.push_back(mk(0, 1, 0, 0,  1,  0, 7, 2'b10, 0, 0, 0,  0, 1, 4'h0,   1)); // R8 x7 from REG
    tbl.push_back(mk(0, 1, 1, 8,  0,  0, 0, 2'b00, 0, 0, 0,  0, 1, 4'h0,   1)); // R9 lat0 as ALU
    tbl.push_back(mk(0, 1, 0, 0,  1,  0, 8, 2'b10, 0, 0, 0,  0, 1, 4'b0100, 1)); // R10 x8 from MEM
    tbl.push_back(mk(0, 1, 1, 9,  3,  0, 0, 2'b00, 0, 0, 0,  0, 1, 4'h0,   1)); // R11 long x9
    tbl.push_back(mk(0, 1, 0, 0,  1,  9, 0, 2'b01, 0, 0, 0,  1, 0, 4'h0,   1)); // R12 wait long
    tbl.push_back(mk(0, 1, 0, 0,  1,  9, 0, 2'b01, 0, 1, 4,  1, 0, 4'h0,   2)); // R13 other cmpl
    tbl.push_back(mk(0, 1, 1, 9,  1,  0, 0, 2'b00, 0, 0, 0,  1, 0, 4'h0,   3)); // R14 WAW
    tbl.push_back(mk(0, 1, 0, 0,  1,  9, 0, 2'b01, 0, 1, 9,  0, 1, 4'h0,   4)); // R15 cmpl cycle
    tbl.push_back(mk(0, 1, 0, 0,  1,  0, 9, 2'b10, 0, 0, 0,  0, 1, 4'h0,   4)); // R16 x9 idle
    tbl.push_back(mk(0, 1, 1, 6,  1,  0, 0, 2'b00, 1, 0, 0,  0, 0, 4'h0,   4)); // R17 flushed add x6
    tbl.push_back(mk(0, 1, 0, 0,  1,  6, 0, 2'b01, 0, 0, 0,  0, 1, 4'h0,   4)); // R18 x6 not busy
    tbl.push_back(mk(0, 1, 1, 10, 2,  0, 0, 2'b00, 0, 0, 0,  0, 1, 4'h0,   4)); // R19 load x10
    tbl.push_back(mk(0, 1, 1, 0,  1, 10, 0, 2'b00, 0, 0, 0,  0, 1, 4'h0,   4)); // R20 unused operand
    tbl.push_back(mk(0, 1, 0, 0,  1,  0, 0, 2'b11, 0, 0, 0,  0, 1, 4'h0,   4)); // R21 x0 operands
    tbl.push_back(mk(0, 1, 1, 11, 2,  0, 0, 2'b00, 0, 0, 0,  0, 1, 4'h0,   4)); // R22 load x11
    tbl.push_back(mk(0, 1, 1, 11, 1,  0, 0, 2'b00, 0, 0, 0,  0, 1, 4'h0,   4)); // R23 add x11
    tbl.push_back(mk(0, 1, 0, 0,  1, 11, 0, 2'b01, 0, 0, 0,  0, 1, 4'b0001, 4)); // R24 newest wins
    tbl.push_back(mk(0, 1, 1, 12, 3,  0, 0, 2'b00, 0, 0, 0,  0, 1, 4'h0,   4)); // R25 long x12
    tbl.push_back(mk(0, 1, 0, 0,  1, 12, 0, 2'b01, 0, 0, 0,  1, 0, 4'h0,   4)); // R26 wait long
    tbl.push_back(mk(1, 1, 0, 0,  1, 12, 0, 2'b01, 0, 0, 0,  0, 1, 4'h0,   5)); // R27 reset
    tbl.push_back(mk(0, 1, 0, 0,  1, 12, 0, 2'b01, 0, 1, 12, 0, 1, 4'h0,   0)); // R28 stale cmpl
    tbl.push_back(mk(0, 1, 0, 0,  1, 12, 0, 2'b01, 0, 0, 0,  0, 1, 4'h0,   0)); // R29 x12 idle
    tbl.push_back(mk(0, 1, 1, 13, 3,  0, 0, 2'b00, 0, 0, 0,  0, 1, 4'h0,   0)); // R30 long x13
    tbl.push_back(mk(0, 0, 0, 0,  1, 13, 0, 2'b01, 0, 0, 0,  0, 0, 4'h0,   0)); // R31 no valid
    tbl.push_back(mk(0, 1, 0, 0,  1, 13, 0, 2'b01, 1, 0, 0,  1, 0, 4'h0,   0)); // R32 flush+stall
    tbl.push_back(mk(0, 0, 0, 0,  1,  0, 0, 2'b00, 0, 0, 0,  0, 0, 4'h0,   1)); // R33 count

    // reset
    drive(1, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].iv, tbl[k].we, tbl[k].rd, tbl[k].lat, tbl[k].s0, tbl[k].s1,
            tbl[k].used, tbl[k].fl, tbl[k].cv, tbl[k].crd);
      #2;
      check($sformatf("row%0d stall", k), 32'(stall0), 32'(tbl[k].e_stall));
      check($sformatf("row%0d accept", k), 32'(acc0), 32'(tbl[k].e_acc));
      if (!tbl[k].e_stall) check($sformatf("row%0d fwd_sel", k), 32'(fwd0), 32'(tbl[k].e_fwd));
      check($sformatf("row%0d stall_count", k), cnt0, tbl[k].e_cnt);
      next_cycle();
    end

    // Disabled bypass paths: ALU x3, then a reader on three successive cycles.
    drive(1, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0);
    next_cycle();
    drive(0, 1, 1, 3, 1, 0, 0, 2'b00, 0, 0, 0);
    #2;
    check("nobyp issue accept u1", 32'(acc1), 32'd1);
    check("nobyp issue accept u2", 32'(acc2), 32'd1);
    next_cycle();
    drive(0, 1, 0, 0, 1, 3, 0, 2'b01, 0, 0, 0);
    #2;
    check("nobyp d1 stall u0", 32'(stall0), 32'd0);
    check("nobyp d1 fwd u0", 32'(fwd0), 32'd1);
    check("nobyp d1 stall u1", 32'(stall1), 32'd1);
    check("nobyp d1 stall u2", 32'(stall2), 32'd1);
    next_cycle();
    #2;
    check("nobyp d2 stall u1", 32'(stall1), 32'd0);
    check("nobyp d2 fwd u1", 32'(fwd1), 32'd2);
    check("nobyp d2 stall u2", 32'(stall2), 32'd1);
    next_cycle();
    #2;
    check("nobyp d3 stall u2", 32'(stall2), 32'd0);
    check("nobyp d3 fwd u2", 32'(fwd2), 32'd0);
    check("nobyp d3 accept u2", 32'(acc2), 32'd1);
    next_cycle();
    drive(0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0);
    #2;
    check("nobyp count u0", cnt0, 32'd0);
    check("nobyp count u1", cnt1, 32'd1);
    check("nobyp count u2", cnt2, 32'd2);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
